inst_prefetch_buffer: RTL and testbench

INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

---
 rtl/inst_prefetch_buffer.sv | 186 ++++++++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// inst_prefetch_buffer
// Instruction prefetch queue between the instruction memory and IF/ID.
// Fetch requests are issued under credit control: a request is only raised when
// (entries held + requests still in flight) < DEPTH, so every response that is
// kept always finds a free slot. On a redirect the queue is flushed, fetch and
// response PCs jump to the new target, and every response still in flight is
// marked for discard so no wrong-path instruction is ever delivered.
//
// Parameters:
//   WIDTH    instruction / PC width
//   DEPTH    queue entries (power of two, >= 2)
//   RESET_PC first fetch address after reset
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   start            synchronous active-high reset
//   redirect         one-cycle flush / branch-taken pulse
//   redirect_pc      new fetch target, valid with redirect
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request
//   imem_req_addr    fetch address
//   imem_resp_valid  in-order response valid (latency >= 1)
//   imem_resp_data   fetched instruction
//   out_valid        head entry valid toward IF/ID
//   out_ready        IF/ID consumes the head entry
//   out_inst         head instruction
//   out_pc           head instruction PC
//   count            occupied entries
//
// Build option:
//   PFB_BYPASS_EN    when defined, a response arriving at an empty queue with
//                    nothing to discard is presented on the outputs in the same
//                    cycle and, if out_ready is high, never written to the queue.
// -----------------------------------------------------------------------------
module inst_prefetch_buffer #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   start,
    input  logic                   redirect,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [WIDTH-1:0]       imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [WIDTH-1:0]       imem_resp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_inst,
    output logic [WIDTH-1:0]       out_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(3'd4);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1'b1);
    localparam logic [CW:0]      DEPTH_W  = (CW+1)'(DEPTH);

    // Queue storage
    logic [WIDTH-1:0] r_mem_inst [DEPTH];
    logic [WIDTH-1:0] r_mem_pc   [DEPTH];

    // Control state
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_resp_pc;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_outstanding;
    logic [CW-1:0]    r_discard;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;

    logic [CW:0]      w_occ_sum;
    logic             w_credit_ok;
    logic             w_req_fire;
    logic             w_resp_live;
    logic             w_resp_keep;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;

    // Credit check and request handshake.
    always_comb begin
        w_occ_sum      = {1'b0, r_count} + {1'b0, r_outstanding};
        w_credit_ok    = (w_occ_sum < DEPTH_W);
        imem_req_valid = !start && !redirect && w_credit_ok;
        imem_req_addr  = r_fetch_pc;
        w_req_fire     = imem_req_valid && imem_req_ready;
    end

    // Response classification: responses during reset are dropped, and a
    // response that is not being discarded is only kept outside a redirect.
    always_comb begin
        w_resp_live = imem_resp_valid && !start;
        w_resp_keep = w_resp_live && (r_discard == {CW{1'b0}}) && !redirect;
    end

    // Head presentation; an empty queue shows zeros unless the bypass path
    // forwards the arriving response.
    always_comb begin
        w_bypass  = 1'b0;
        out_valid = 1'b0;
        out_inst  = {WIDTH{1'b0}};
        out_pc    = {WIDTH{1'b0}};
        if (r_count != {CW{1'b0}}) begin
            out_valid = !start;
            out_inst  = r_mem_inst[r_rd_ptr];
            out_pc    = r_mem_pc[r_rd_ptr];
        end else begin
`ifdef PFB_BYPASS_EN
            if (w_resp_keep) begin
                w_bypass  = 1'b1;
                out_valid = 1'b1;
                out_inst  = imem_resp_data;
                out_pc    = r_resp_pc;
            end else begin
                w_bypass  = 1'b0;
            end
`else
            w_bypass  = 1'b0;
`endif
        end
    end

    // Push / pop decisions; a bypassed response taken by IF/ID skips the queue.
    always_comb begin
        w_push = w_resp_keep && !(w_bypass && out_ready);
        w_pop  = out_valid && out_ready && (r_count != {CW{1'b0}}) && !redirect;
    end

    // Queue storage write; contents need no reset because count gates the head.
    always_ff @(posedge clk) begin
        if (!start && !redirect && w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_resp_data;
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

    // Pointers, occupancy, PCs and the outstanding/discard credit counters.
    always_ff @(posedge clk) begin
        if (start) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= {CW{1'b0}};
            r_outstanding <= {CW{1'b0}};
            r_discard     <= {CW{1'b0}};
            r_rd_ptr      <= {PW{1'b0}};
            r_wr_ptr      <= {PW{1'b0}};
        end else if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_fetch_pc    <= redirect_pc;
            r_resp_pc     <= redirect_pc;
            r_count       <= {CW{1'b0}};
            r_outstanding <= r_outstanding - CW'(w_resp_live);
            r_discard     <= r_outstanding - CW'(w_resp_live);
            r_rd_ptr      <= {PW{1'b0}};
            r_wr_ptr      <= {PW{1'b0}};
        end else begin
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp_live);
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (w_resp_keep) begin
                r_resp_pc <= r_resp_pc + PC_STEP;
            end
            if (w_resp_live && (r_discard != {CW{1'b0}})) begin
                r_discard <= r_discard - CNT_ONE;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for inst_prefetch_buffer. A behavioural memory with configurable
// in-order latency answers requests; a queue-based reference model predicts
// every output each cycle. Directed scenarios cover start-up, back-pressure,
// redirect with stale responses, mid-stream reset and PC wrap-around, followed
// by a randomized phase.
// -----------------------------------------------------------------------------
module tb_inst_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        start;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  count;

    inst_prefetch_buffer #(
        .WIDTH    (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .start           (start),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .count           (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat_lo   = 1;
    int lat_hi   = 1;

    // Memory: in-order pending requests with the cycle each may answer
    logic [31:0] mem_q_addr [$];
    int          mem_q_due  [$];

    // Reference model state
    logic [31:0] m_q_pc   [$];
    logic [31:0] m_q_inst [$];
    logic [31:0] m_fetch_pc = RESET_PC;
    logic [31:0] m_resp_pc  = RESET_PC;
    int          m_out  = 0;
    int          m_disc = 0;

    // Observed DUT events for directed scenarios
    logic [31:0] obs_req_addr [$];
    int          obs_req_cyc  [$];
    logic [31:0] obs_out_pc   [$];
    logic [31:0] obs_out_inst [$];
    int          obs_out_cyc  [$];

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] obs_req_at(input int i);
        return (i < obs_req_addr.size()) ? obs_req_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] obs_pc_at(input int i);
        return (i < obs_out_pc.size()) ? obs_out_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] obs_inst_at(input int i);
        return (i < obs_out_inst.size()) ? obs_out_inst[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_req_addr.delete();
        obs_req_cyc.delete();
        obs_out_pc.delete();
        obs_out_inst.delete();
        obs_out_cyc.delete();
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance model.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic rdy, input logic ordy);
        logic        resp_v, e_req_v, e_out_v, byp, byp_taken;
        logic [31:0] resp_d, e_inst, e_pc;
        int          sz;
        sz     = m_q_pc.size();
        resp_v = 1'b0;
        resp_d = $urandom();
        if (st) begin
            mem_q_addr.delete();
            mem_q_due.delete();
        end else if (mem_q_addr.size() > 0 && mem_q_due[0] <= cyc) begin
            resp_v = 1'b1;
            resp_d = inst_of(mem_q_addr[0]);
            void'(mem_q_addr.pop_front());
            void'(mem_q_due.pop_front());
        end
        start           = st;
        redirect        = rd;
        redirect_pc     = rpc;
        imem_req_ready  = rdy;
        out_ready       = ordy;
        imem_resp_valid = resp_v;
        imem_resp_data  = resp_d;
        #1;
        e_req_v = !st && !rd && ((sz + m_out) < DEPTH);
        byp     = 1'b0;
`ifdef PFB_BYPASS_EN
        byp     = !st && !rd && (sz == 0) && (m_disc == 0) && resp_v;
`endif
        e_out_v = (!st && sz > 0) || byp;
        e_inst  = (sz > 0) ? m_q_inst[0] : resp_d;
        e_pc    = (sz > 0) ? m_q_pc[0]   : m_resp_pc;
        check_value("req_valid", 32'(imem_req_valid), 32'(e_req_v));
        if (e_req_v) check_value("req_addr", imem_req_addr, m_fetch_pc);
        check_value("out_valid", 32'(out_valid), 32'(e_out_v));
        if (e_out_v) begin
            check_value("out_inst", out_inst, e_inst);
            check_value("out_pc", out_pc, e_pc);
        end
        check_value("count", 32'(count), 32'(sz));
        if (imem_req_valid && rdy) begin
            obs_req_addr.push_back(imem_req_addr);
            obs_req_cyc.push_back(cyc);
        end
        if (out_valid && ordy && !rd && !st) begin
            obs_out_pc.push_back(out_pc);
            obs_out_inst.push_back(out_inst);
            obs_out_cyc.push_back(cyc);
        end
        // Memory accepts the request the model says is on the bus
        if (e_req_v && rdy) begin
            mem_q_addr.push_back(m_fetch_pc);
            mem_q_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
        end
        // Model update
        if (st) begin
            m_q_pc.delete();
            m_q_inst.delete();
            m_fetch_pc = RESET_PC;
            m_resp_pc  = RESET_PC;
            m_out      = 0;
            m_disc     = 0;
        end else if (rd) begin
            m_q_pc.delete();
            m_q_inst.delete();
            m_fetch_pc = rpc;
            m_resp_pc  = rpc;
            if (resp_v) m_out = m_out - 1;
            m_disc = m_out;
        end else begin
            byp_taken = byp && ordy;
            if (sz > 0 && ordy) begin
                void'(m_q_pc.pop_front());
                void'(m_q_inst.pop_front());
            end
            if (resp_v) begin
                m_out = m_out - 1;
                if (m_disc == 0) begin
                    if (!byp_taken) begin
                        m_q_pc.push_back(m_resp_pc);
                        m_q_inst.push_back(resp_d);
                    end
                    m_resp_pc = m_resp_pc + 32'd4;
                end else begin
                    m_disc = m_disc - 1;
                end
            end
            if (e_req_v && rdy) begin
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_out      = m_out + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int lat_obs;
        int guard;
        start = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; out_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check_value("rst_out_valid", 32'(out_valid), 32'h0);
        check_value("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check_value("rst_out_inst", out_inst, 32'h0);
        check_value("rst_out_pc", out_pc, 32'h0);
        check_value("rst_count", 32'(count), 32'h0);

        // Start-up stream, latency 1, no stall
        lat_lo = 1; lat_hi = 1;
        clear_obs();
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_value("boot_req0", obs_req_at(0), 32'h0);
        check_value("boot_req1", obs_req_at(1), 32'h4);
        check_value("boot_req2", obs_req_at(2), 32'h8);
        check_value("boot_pc0", obs_pc_at(0), 32'h0);
        check_value("boot_pc1", obs_pc_at(1), 32'h4);
        check_value("boot_pc2", obs_pc_at(2), 32'h8);
        check_value("boot_inst1", obs_inst_at(1), inst_of(32'h4));
        lat_obs = (obs_out_cyc.size() > 0 && obs_req_cyc.size() > 0) ?
                  (obs_out_cyc[0] - obs_req_cyc[0]) : -1;
`ifdef PFB_BYPASS_EN
        check_value("boot_latency", 32'(lat_obs), 32'd1);
`else
        check_value("boot_latency", 32'(lat_obs), 32'd2);
`endif

        // Back-pressure: queue fills to DEPTH, then one pop frees one credit
        do_reset();
        clear_obs();
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_value("stall_reqs", 32'(obs_req_addr.size()), 32'd4);
        check_value("stall_req_valid", 32'(imem_req_valid), 32'h0);
        check_value("stall_count", 32'(count), 32'd4);
        clear_obs();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_value("stall_one_more", 32'(obs_req_addr.size()), 32'd1);

        // Redirect with two stale responses in flight (latency 3)
        do_reset();
        lat_lo = 3; lat_hi = 3;
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
        lat_lo = 1; lat_hi = 1;
        clear_obs();
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_value("redir_req0", obs_req_at(0), 32'h100);
        check_value("redir_pc0", obs_pc_at(0), 32'h100);
        check_value("redir_inst0", obs_inst_at(0), inst_of(32'h100));

        // Redirect coinciding with pop and response in steady stream
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        check_value("redir_pop_count", 32'(count), 32'h0);
        check_value("redir_pop_valid", 32'(out_valid), 32'h0);
        clear_obs();
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_value("redir_pop_pc0", obs_pc_at(0), 32'h200);

        // Reset mid-stream with three entries held
        guard = 0;
        while (m_q_pc.size() != 3 && guard < 20) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            guard++;
        end
        check_value("mid_rst_pre_count", 32'(count), 32'd3);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_value("mid_rst_count", 32'(count), 32'h0);
        check_value("mid_rst_valid", 32'(out_valid), 32'h0);
        clear_obs();
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_value("mid_rst_req0", obs_req_at(0), RESET_PC);
        check_value("mid_rst_pc0", obs_pc_at(0), RESET_PC);

        // PC wrap-around at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        clear_obs();
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_value("wrap_pc0", obs_pc_at(0), 32'hFFFF_FFF8);
        check_value("wrap_pc1", obs_pc_at(1), 32'hFFFF_FFFC);
        check_value("wrap_pc2", obs_pc_at(2), 32'h0000_0000);

        // Randomized traffic against the reference model
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            logic r_st, r_rd, r_rdy, r_ordy;
            r_st   = ($urandom_range(199, 0) == 0);
            r_rd   = ($urandom_range(19, 0) == 0);
            r_rdy  = ($urandom_range(3, 0) != 0);
            r_ordy = ($urandom_range(3, 0) != 0);
            step(r_st, r_rd, $urandom() & 32'hFFFF_FFFC, r_rdy, r_ordy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
